// File: rtl/leg_mem_pkg.sv
// Shared constants, state encodings and payload types for the cache-line burst controller.
package leg_mem_pkg;

    localparam int unsigned BLOCKSIZE_DEF = 4;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned CNT_W         = 2;
    localparam int unsigned LINE_W        = ADDR_W - 4;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITEBACK = 2'd1;
    localparam logic [1:0] ST_FILL      = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    // Memory-side request payload for one beat.
    typedef struct packed {
        logic [ADDR_W-1:0] haddr;
        logic [DATA_W-1:0] hwdata;
        logic              hwrite;
        logic              hread;
        logic              hsel;
    } mem_req_t;

    // Word address of beat `cnt` within a line.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [LINE_W-1:0] line,
                                                    input logic [CNT_W-1:0]  cnt);
        return {line, cnt, 2'b00};
    endfunction

endpackage

// File: rtl/mem_burst_ctrl_if.sv
// Cache-side and memory-side signals of the burst controller, with modports for both ends.
interface mem_burst_ctrl_if;
    import leg_mem_pkg::*;

    logic              Fill;
    logic              WB;
    logic [ADDR_W-1:0] FillAddr;
    logic [ADDR_W-1:0] WBAddr;
    logic [DATA_W-1:0] WBData;
    logic [DATA_W-1:0] HRData;
    logic              HReady;

    logic [ADDR_W-1:0] HAddr;
    logic [DATA_W-1:0] HWData;
    logic              HWrite;
    logic              HRead;
    logic              HSEL;
    logic [DATA_W-1:0] FillData;
    logic              FillWe;
    logic [CNT_W-1:0]  WordOffset;
    logic              Busy;
    logic              Done;

    modport slave (
        input  Fill, WB, FillAddr, WBAddr, WBData, HRData, HReady,
        output HAddr, HWData, HWrite, HRead, HSEL, FillData, FillWe, WordOffset, Busy, Done
    );

    modport master (
        output Fill, WB, FillAddr, WBAddr, WBData, HRData, HReady,
        input  HAddr, HWData, HWrite, HRead, HSEL, FillData, FillWe, WordOffset, Busy, Done
    );

endinterface

// File: rtl/mem_burst_ctrl.sv
// Line-fill / writeback burst controller: moves a cache line as BLOCKSIZE word beats,
// writeback first when both are requested, then a single Done pulse.
module mem_burst_ctrl
    import leg_mem_pkg::*;
#(
    parameter int unsigned BLOCKSIZE = BLOCKSIZE_DEF
) (
    input logic             clk,
    input logic             reset,
    mem_burst_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCKSIZE - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [LINE_W-1:0] r_fill_line;
    logic [LINE_W-1:0] r_wb_line;
    logic              r_fill_pend;

    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [LINE_W-1:0] w_fill_line_nxt;
    logic [LINE_W-1:0] w_wb_line_nxt;
    logic              w_fill_pend_nxt;

    mem_req_t          w_req;
    logic [DATA_W-1:0] w_fill_data;
    logic              w_fill_we;
    logic              w_unused;

    // Line offsets are ignored; requests are always whole, aligned lines.
    assign w_unused = ^{bus.FillAddr[3:0], bus.WBAddr[3:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_fill_line <= '0;
            r_wb_line   <= '0;
            r_fill_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_fill_line <= w_fill_line_nxt;
            r_wb_line   <= w_wb_line_nxt;
            r_fill_pend <= w_fill_pend_nxt;
        end
    end

    // Next-state and beat decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_fill_line_nxt = r_fill_line;
        w_wb_line_nxt   = r_wb_line;
        w_fill_pend_nxt = r_fill_pend;
        w_req           = '0;
        w_fill_data     = '0;
        w_fill_we       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.WB || bus.Fill) begin
                    w_fill_line_nxt = bus.FillAddr[ADDR_W-1:4];
                    w_wb_line_nxt   = bus.WBAddr[ADDR_W-1:4];
                    w_cnt_nxt       = '0;
                    // A fill arriving with a writeback waits until the writeback finishes.
                    w_fill_pend_nxt = bus.WB && bus.Fill;
                    w_state_nxt     = bus.WB ? ST_WRITEBACK : ST_FILL;
                end
            end

            ST_WRITEBACK: begin
                w_req.hsel   = 1'b1;
                w_req.hwrite = 1'b1;
                w_req.haddr  = beat_addr(r_wb_line, r_cnt);
                w_req.hwdata = bus.WBData;
                if (bus.HReady) begin
                    if (r_cnt == LAST_BEAT) begin
                        w_cnt_nxt       = '0;
                        w_fill_pend_nxt = 1'b0;
                        w_state_nxt     = r_fill_pend ? ST_FILL : ST_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end

            ST_FILL: begin
                w_req.hsel  = 1'b1;
                w_req.hread = 1'b1;
                w_req.haddr = beat_addr(r_fill_line, r_cnt);
                w_fill_data = bus.HRData;
                w_fill_we   = bus.HReady;
                if (bus.HReady) begin
                    if (r_cnt == LAST_BEAT) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs decode from the state register; data and write-enable pass through in the beat cycle.
    assign bus.HAddr      = w_req.haddr;
    assign bus.HWData     = w_req.hwdata;
    assign bus.HWrite     = w_req.hwrite;
    assign bus.HRead      = w_req.hread;
    assign bus.HSEL       = w_req.hsel;
    assign bus.FillData   = w_fill_data;
    assign bus.FillWe     = w_fill_we;
    assign bus.WordOffset = r_cnt;
    assign bus.Busy       = (r_state != ST_IDLE);
    assign bus.Done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl: expected beats are queued at request time and
// checked against the memory-side traffic as it appears.
module tb_mem_burst_ctrl;
    import leg_mem_pkg::*;

    localparam logic [31:0] WBD_BASE = 32'hB0B0_0000;
    localparam logic [31:0] RD_KEY   = 32'h5A5A_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        write;
        logic [1:0]  off;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    beat_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    mem_burst_ctrl_if bus ();

    mem_burst_ctrl #(.BLOCKSIZE(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Cache word source and memory read data models.
    assign bus.WBData = WBD_BASE | 32'(bus.WordOffset);
    assign bus.HRData = bus.HAddr ^ RD_KEY;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input logic [31:0] line_addr, input logic wr);
        logic [31:0] a;
        logic [31:0] d;
        for (int k = 0; k < 4; k++) begin
            a = {line_addr[31:4], 2'(k), 2'b00};
            d = wr ? (WBD_BASE | 32'(k)) : (a ^ RD_KEY);
            sb.push_back('{addr: a, data: d, write: wr, off: 2'(k)});
        end
    endtask

    task automatic start_req(input logic f, input logic w, input logic [31:0] fa, input logic [31:0] wa);
        bus.Fill     = f;
        bus.WB       = w;
        bus.FillAddr = fa;
        bus.WBAddr   = wa;
        if (w) push_line(wa, 1'b1);
        if (f) push_line(fa, 1'b0);
        cyc();
        bus.Fill = 1'b0;
        bus.WB   = 1'b0;
    endtask

    // Follows one transfer cycle by cycle until Done, with optional stall, busy-time pulse and DONE-cycle request.
    task automatic run_xfer(input int exp_done, input int exp_beats, input int stall_at,
                            input int stall_len, input int pulse_cyc, input bit done_req);
        int    beats   = 0;
        int    stalled = 0;
        bit    seen    = 1'b0;
        beat_t e;
        for (int n = 1; n <= 20 && !seen; n++) begin
            bus.HReady = 1'b1;
            if (bus.HSEL) begin
                if (beats == stall_at && stalled < stall_len) begin
                    bus.HReady = 1'b0;
                    stalled++;
                end
                #1;
                chk("beat_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb[0];
                    chk("haddr", bus.HAddr, e.addr);
                    chk("hwrite", 32'(bus.HWrite), 32'(e.write));
                    chk("hread", 32'(bus.HRead), 32'(!e.write));
                    chk("word_offset", 32'(bus.WordOffset), 32'(e.off));
                    if (e.write) begin
                        chk("hwdata", bus.HWData, e.data);
                        chk("fillwe_wb", 32'(bus.FillWe), 32'd0);
                    end else begin
                        chk("fillwe", 32'(bus.FillWe), 32'(bus.HReady));
                        if (bus.HReady) chk("filldata", bus.FillData, e.data);
                    end
                    if (bus.HReady) begin
                        void'(sb.pop_front());
                        beats++;
                    end
                end
            end else begin
                #1;
            end
            chk("busy", 32'(bus.Busy), 32'd1);
            if (bus.Done) begin
                seen = 1'b1;
                chk("done_cycle", 32'(n), 32'(exp_done));
                chk("beat_count", 32'(beats), 32'(exp_beats));
                chk("sb_empty", 32'(sb.size()), 32'd0);
                chk("done_hsel", 32'(bus.HSEL), 32'd0);
            end
            bus.Fill     = (n == pulse_cyc) || (seen && done_req);
            bus.FillAddr = (n == pulse_cyc) ? 32'h0000_9990 : bus.FillAddr;
            cyc();
        end
        bus.Fill = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        chk("idle_busy", 32'(bus.Busy), 32'd0);
        chk("idle_done", 32'(bus.Done), 32'd0);
        chk("idle_hsel", 32'(bus.HSEL), 32'd0);
        if (done_req) begin
            cyc();
            chk("done_req_ignored", 32'(bus.Busy), 32'd0);
        end
        sb.delete();
    endtask

    initial begin
        // Reset wins over simultaneous requests.
        reset        = 1'b1;
        bus.Fill     = 1'b1;
        bus.WB       = 1'b1;
        bus.FillAddr = 32'h0000_1238;
        bus.WBAddr   = 32'h0000_2000;
        bus.HReady   = 1'b1;
        cyc();
        cyc();
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_hsel", 32'(bus.HSEL), 32'd0);
        chk("rst_done", 32'(bus.Done), 32'd0);
        chk("rst_haddr", bus.HAddr, 32'd0);
        chk("rst_fillwe", 32'(bus.FillWe), 32'd0);
        chk("rst_woff", 32'(bus.WordOffset), 32'd0);
        chk("rst_hrw", 32'({bus.HRead, bus.HWrite}), 32'd0);
        reset    = 1'b0;
        bus.Fill = 1'b0;
        bus.WB   = 1'b0;
        cyc();
        chk("idle_after_rst", 32'(bus.Busy), 32'd0);

        // Fill only, no stalls.
        start_req(1'b1, 1'b0, 32'h0000_1238, 32'h0);
        run_xfer(5, 4, -1, 0, 0, 1'b0);

        // Writeback then pending fill, single Done.
        start_req(1'b1, 1'b1, 32'h0000_3010, 32'h0000_2000);
        run_xfer(9, 8, -1, 0, 0, 1'b0);

        // Two-cycle stall on beat 1.
        start_req(1'b1, 1'b0, 32'h0000_1238, 32'h0);
        run_xfer(7, 4, 1, 2, 0, 1'b0);

        // Writeback only, with a request during DONE that must be dropped.
        start_req(1'b0, 1'b1, 32'h0, 32'h0000_4000);
        run_xfer(5, 4, -1, 0, 0, 1'b1);

        // Fill pulse while busy is ignored.
        start_req(1'b1, 1'b0, 32'h0000_7740, 32'h0);
        run_xfer(5, 4, -1, 0, 2, 1'b0);

        // Reset in cycle 2 of a fill aborts it.
        start_req(1'b1, 1'b0, 32'h0000_5670, 32'h0);
        bus.HReady = 1'b1;
        chk("abort_c1_hsel", 32'(bus.HSEL), 32'd1);
        chk("abort_c1_haddr", bus.HAddr, 32'h0000_5670);
        cyc();
        chk("abort_c2_haddr", bus.HAddr, 32'h0000_5674);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        sb.delete();
        for (int n = 0; n < 6; n++) begin
            chk("abort_busy", 32'(bus.Busy), 32'd0);
            chk("abort_hsel", 32'(bus.HSEL), 32'd0);
            chk("abort_done", 32'(bus.Done), 32'd0);
            chk("abort_fillwe", 32'(bus.FillWe), 32'd0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_burst_ctrl.md
MEM_BURST_CTRL -- requirements
Module: mem_burst_ctrl

Interface
REQ-001 Parameter BLOCKSIZE, default 4, is the number of 32-bit words per cache line (fixed at 4 in this release).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port Fill, input, 1, a line-fill request from the data cache.
REQ-005 The block SHALL have port WB, input, 1, a dirty-line writeback request from the data cache.
REQ-006 The block SHALL have ports FillAddr and WBAddr, input, 32 each; bits [3:0] are ignored (line-aligned).
REQ-007 The block SHALL have port WBData, input, 32, the cache word at WordOffset, valid combinationally.
REQ-008 The block SHALL have port HRData, input, 32, read data from memory.
REQ-009 The block SHALL have port HReady, input, 1, the memory beat acknowledge (memory Valid).
REQ-010 The block SHALL have outputs HAddr (32), HWData (32), HWrite (1), HRead (1) and HSEL (1), the memory-side request.
REQ-011 The block SHALL have outputs FillData (32), FillWe (1) and WordOffset (2), the cache-side word transfer.
REQ-012 The block SHALL have outputs Busy (1), high in any non-IDLE state, and Done (1), a one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have states IDLE, WRITEBACK, FILL and DONE.
REQ-014 Fill and WB SHALL be sampled only in IDLE; on acceptance, FillAddr[31:4] and WBAddr[31:4] are latched; requests while Busy are ignored.
REQ-015 On IDLE with WB=1, the next state SHALL be WRITEBACK, and a pending Fill is latched for later service.
REQ-016 On IDLE with Fill=1 and WB=0, the next state SHALL be FILL.
REQ-017 Entering WRITEBACK or FILL SHALL clear the 2-bit beat counter to 0.
REQ-018 Each beat SHALL use HAddr = {latched line[31:4], counter, 2'b00}, with WordOffset = counter.
REQ-019 In WRITEBACK, the block SHALL drive HSEL=1, HWrite=1, HRead=0 and HWData=WBData.
REQ-020 In FILL, the block SHALL drive HSEL=1, HRead=1, HWrite=0, FillData=HRData and FillWe=HReady.
REQ-021 A beat SHALL complete at a rising edge with HReady=1; the counter then increments, and with HReady=0 the request and counter hold (stall, unbounded).
REQ-022 After beat BLOCKSIZE-1 completes, the counter SHALL wrap to 0 and the FSM go to FILL if a fill is pending, else to DONE.
REQ-023 DONE SHALL last exactly one cycle with Done=1 and then return to IDLE; a request in the DONE cycle is ignored.
REQ-024 WB-only SHALL end with Done after the writeback; Fill+WB produces a single Done after the fill.
REQ-025 Latency without stalls SHALL be: fill-only Done 5 cycles after acceptance edge; writeback+fill 9 cycles.
REQ-026 In IDLE and DONE, HSEL, HRead, HWrite and FillWe SHALL be 0; HAddr/HWData are don't-care but are driven 0.

Reset
REQ-027 Reset SHALL, at the next rising edge, place the FSM in IDLE, clear the counter, latched addresses and pending-fill flag, and drive all outputs to 0.
REQ-028 Reset mid-transfer SHALL abort the transfer with no Done pulse and no further FillWe or HSEL.
REQ-029 Reset SHALL take priority over simultaneous Fill/WB.

Structure
REQ-030 The state enum and BLOCKSIZE constant SHALL live in shared package leg_mem_pkg.
REQ-031 The block SHALL be a single module with no sub-modules; the beat counter is inline.

Verification
REQ-032 Fill=1, FillAddr=0x0000_1238, HReady=1 SHALL produce HAddr 0x1230/0x1234/0x1238/0x123C in cycles 1-4, FillWe each cycle, WordOffset 0..3, and Done in cycle 5.
REQ-033 WB=1, Fill=1, WBAddr=0x2000, FillAddr=0x3010 SHALL produce 4 writes to 0x2000-0x200C with HWData=WBData, then 4 reads at 0x3010-0x301C, and a single Done in cycle 9.
REQ-034 A fill with HReady low 2 cycles on beat 1 SHALL hold HAddr=line+4 for 3 cycles, assert no FillWe during the stall, and give Done in cycle 7.
REQ-035 Reset asserted in cycle 2 of a fill SHALL give Busy=0 and HSEL=0 from the next cycle, with no Done.
REQ-036 Fill pulsed in cycle 2 of an active fill SHALL be ignored: exactly 4 beats and one Done.
